// File: rtl/axi_rw_dir_sched_pkg.sv
// Shared types for the read/write direction scheduler: FSM states, priority
// encoding and a default AXI request/response struct pair.
package axi_rw_dir_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN_R,
    ST_WRITE,
    ST_DRAIN_W
  } state_e;

  localparam logic PRIO_READ  = 1'b0;
  localparam logic PRIO_WRITE = 1'b1;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } dflt_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } dflt_resp_t;

endpackage

// File: rtl/axi_rw_dir_sched_if.sv
// One AXI port as a request/response struct pair.
// Handshake: a beat transfers on a clock edge where valid & ready; once
// valid is raised it stays up, payload unchanged, until that edge.
interface axi_rw_dir_sched_if;
  import axi_rw_dir_sched_pkg::*;

  dflt_req_t  req;
  dflt_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/axi_rw_txn_cnt.sv
// Outstanding-transaction up/down counter; simultaneous inc and dec cancel.
module axi_rw_txn_cnt #(
  parameter int unsigned MaxCnt = 4,
  parameter int unsigned Width  = $clog2(MaxCnt + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             at_max_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) cnt_d = cnt_q + Width'(1);
    else if (!inc_i && dec_i) cnt_d = cnt_q - Width'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == Width'(MaxCnt));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    dec_i |-> (cnt_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (inc_i && !dec_i) |-> !at_max_o);

endmodule

// File: rtl/axi_rw_dir_sched.sv
// Serialises AXI reads and writes: one direction outstanding at a time, the
// active direction is drained before the other is granted, round-robin.
module axi_rw_dir_sched
  import axi_rw_dir_sched_pkg::*;
#(
  parameter int unsigned MaxTxns = 4,
  parameter type axi_req_t  = dflt_req_t,
  parameter type axi_resp_t = dflt_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i,
  output logic      rd_active_o,
  output logic      wr_active_o
);

  localparam int unsigned CntWidth = $clog2(MaxTxns + 1);

  state_e              state_q;
  logic                prio_q, ar_hold_q, aw_hold_q, rd_active_q, wr_active_q;
  logic [CntWidth-1:0] rd_cnt, wr_cnt;
  logic                rd_at_max, wr_at_max;
  logic                ar_en, aw_en, w_en, ar_hs, aw_hs, r_last_hs, b_hs;
  logic                ar_pend, aw_pend, ar_lock, aw_lock;

  // A hold keeps a presented-but-unaccepted address granted until it transfers.
  assign ar_en = ar_hold_q | ((state_q == ST_READ)  & ~rd_at_max);
  assign aw_en = aw_hold_q | ((state_q == ST_WRITE) & ~wr_at_max);
  assign w_en  = (state_q == ST_WRITE) | (state_q == ST_DRAIN_W);

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_en;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_en;
    mst_req_o.w_valid   = slv_req_i.w_valid  & w_en;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_en;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_en;
    slv_resp_o.w_ready  = mst_resp_i.w_ready  & w_en;
  end

  assign ar_hs     = slv_req_i.ar_valid & ar_en &  mst_resp_i.ar_ready;
  assign ar_pend   = slv_req_i.ar_valid & ar_en & ~mst_resp_i.ar_ready;
  assign aw_hs     = slv_req_i.aw_valid & aw_en &  mst_resp_i.aw_ready;
  assign aw_pend   = slv_req_i.aw_valid & aw_en & ~mst_resp_i.aw_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  // Include the not-yet-registered pending case so valid never drops early.
  assign ar_lock   = ar_hold_q | ar_pend;
  assign aw_lock   = aw_hold_q | aw_pend;

  axi_rw_txn_cnt #(.MaxCnt(MaxTxns), .Width(CntWidth)) u_rd_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(ar_hs), .dec_i(r_last_hs),
    .cnt_o(rd_cnt), .at_max_o(rd_at_max)
  );

  axi_rw_txn_cnt #(.MaxCnt(MaxTxns), .Width(CntWidth)) u_wr_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(aw_hs), .dec_i(b_hs),
    .cnt_o(wr_cnt), .at_max_o(wr_at_max)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      prio_q      <= PRIO_READ;
      ar_hold_q   <= 1'b0;
      aw_hold_q   <= 1'b0;
      rd_active_q <= 1'b0;
      wr_active_q <= 1'b0;
    end else begin
      ar_hold_q <= ar_pend;
      aw_hold_q <= aw_pend;
      case (state_q)
        ST_IDLE: begin
          if (slv_req_i.ar_valid && (!slv_req_i.aw_valid || prio_q == PRIO_READ)) begin
            state_q     <= ST_READ;
            prio_q      <= PRIO_WRITE;
            rd_active_q <= 1'b1;
          end else if (slv_req_i.aw_valid) begin
            state_q     <= ST_WRITE;
            prio_q      <= PRIO_READ;
            wr_active_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (!ar_lock) begin
            if (slv_req_i.aw_valid) begin
              state_q <= ST_DRAIN_R;
            end else if (!slv_req_i.ar_valid && rd_cnt == '0) begin
              state_q     <= ST_IDLE;
              rd_active_q <= 1'b0;
            end
          end
        end
        ST_DRAIN_R: begin
          if (rd_cnt == '0) begin
            state_q     <= ST_WRITE;
            prio_q      <= PRIO_READ;
            rd_active_q <= 1'b0;
            wr_active_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!aw_lock) begin
            if (slv_req_i.ar_valid) begin
              state_q <= ST_DRAIN_W;
            end else if (!slv_req_i.aw_valid && wr_cnt == '0) begin
              state_q     <= ST_IDLE;
              wr_active_q <= 1'b0;
            end
          end
        end
        ST_DRAIN_W: begin
          if (wr_cnt == '0) begin
            state_q     <= ST_READ;
            prio_q      <= PRIO_WRITE;
            wr_active_q <= 1'b0;
            rd_active_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rd_active_q <= 1'b0;
          wr_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_active_o = rd_active_q;
  assign wr_active_o = wr_active_q;

  a_r_needs_txn: assert property (@(posedge clk_i) disable iff (rst_i)
    (mst_resp_i.r_valid && slv_req_i.r_ready) |-> (rd_cnt != '0));
  a_b_needs_txn: assert property (@(posedge clk_i) disable iff (rst_i)
    b_hs |-> (wr_cnt != '0));
  a_one_dir: assert property (@(posedge clk_i) disable iff (rst_i)
    !((rd_cnt != '0) && (wr_cnt != '0)));

endmodule

// File: tb/tb_axi_rw_dir_sched.sv
// Directed bench for axi_rw_dir_sched with MaxTxns=4.
module tb_axi_rw_dir_sched;
  import axi_rw_dir_sched_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic rd_active, wr_active;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk_i = ~clk_i;

  axi_rw_dir_sched_if up_if ();
  axi_rw_dir_sched_if dn_if ();

  axi_rw_dir_sched #(.MaxTxns(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .slv_req_i  (up_if.req),
    .slv_resp_o (up_if.resp),
    .mst_req_o  (dn_if.req),
    .mst_resp_i (dn_if.resp),
    .rd_active_o(rd_active),
    .wr_active_o(wr_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    up_if.req           = '0;
    up_if.req.r_ready   = 1'b1;
    up_if.req.b_ready   = 1'b1;
    dn_if.resp          = '0;
    dn_if.resp.ar_ready = 1'b1;
    dn_if.resp.aw_ready = 1'b1;
    dn_if.resp.w_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] data);
    dn_if.resp.r_valid  = 1'b1;
    dn_if.resp.r.last   = 1'b1;
    dn_if.resp.r.data   = data;
    settle();
    check("r_data_pass", up_if.resp.r.data, data);
    tick();
    dn_if.resp.r_valid  = 1'b0;
    dn_if.resp.r.last   = 1'b0;
  endtask

  task automatic b_beat();
    dn_if.resp.b_valid = 1'b1;
    settle();
    check("b_valid_pass", 32'(up_if.resp.b_valid), 32'd1);
    tick();
    dn_if.resp.b_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int hs;
    int wbeats;

    // Reset state, then asynchronous reset in the middle of a held AR.
    idle_inputs();
    up_if.req.ar_valid  = 1'b1;
    dn_if.resp.ar_ready = 1'b0;
    settle();
    check("rst_mst_ar_valid", 32'(dn_if.req.ar_valid), 32'd0);
    check("rst_slv_ar_ready", 32'(up_if.resp.ar_ready), 32'd0);
    check("rst_slv_aw_ready", 32'(up_if.resp.aw_ready), 32'd0);
    check("rst_slv_w_ready", 32'(up_if.resp.w_ready), 32'd0);
    check("rst_rd_active", 32'(rd_active), 32'd0);
    check("rst_wr_active", 32'(wr_active), 32'd0);
    tick();
    tick();
    rst_i = 1'b0;
    settle();
    check("rel_rd_active", 32'(rd_active), 32'd0);
    tick();
    check("grant_rd_active", 32'(rd_active), 32'd1);
    check("grant_mst_ar_valid", 32'(dn_if.req.ar_valid), 32'd1);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_mst_ar_valid", 32'(dn_if.req.ar_valid), 32'd0);
    check("midrst_rd_active", 32'(rd_active), 32'd0);
    tick();
    rst_i = 1'b0;
    settle();
    check("rel2_rd_active", 32'(rd_active), 32'd0);
    tick();
    check("rel2_grant_rd_active", 32'(rd_active), 32'd1);
    do_reset();

    // Contention with prio=read, then AR stalled 3 cycles while AW waits.
    up_if.req.ar_valid  = 1'b1;
    up_if.req.ar.addr   = 32'h0000_1000;
    up_if.req.aw_valid  = 1'b1;
    dn_if.resp.ar_ready = 1'b0;
    settle();
    check("c_idle_mst_ar_valid", 32'(dn_if.req.ar_valid), 32'd0);
    check("c_idle_mst_aw_valid", 32'(dn_if.req.aw_valid), 32'd0);
    tick();
    check("c_prio0_rd_active", 32'(rd_active), 32'd1);
    check("c_prio0_wr_active", 32'(wr_active), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("c_hold_mst_ar_valid", 32'(dn_if.req.ar_valid), 32'd1);
      check("c_hold_slv_aw_ready", 32'(up_if.resp.aw_ready), 32'd0);
      check("c_hold_rd_active", 32'(rd_active), 32'd1);
      tick();
    end
    dn_if.resp.ar_ready = 1'b1;
    settle();
    check("c_ar_addr_pass", dn_if.req.ar.addr, 32'h0000_1000);
    check("c_ar_hs", 32'(up_if.resp.ar_ready), 32'd1);
    tick();
    up_if.req.ar_valid = 1'b0;
    settle();
    check("c_post_hs_rd_active", 32'(rd_active), 32'd1);
    tick();
    check("c_drain_rd_active", 32'(rd_active), 32'd1);
    check("c_drain_slv_aw_ready", 32'(up_if.resp.aw_ready), 32'd0);
    r_beat(32'hCAFE_0001);
    check("c_drain0_rd_active", 32'(rd_active), 32'd1);
    check("c_drain0_wr_active", 32'(wr_active), 32'd0);
    tick();
    check("c_write_wr_active", 32'(wr_active), 32'd1);
    check("c_write_rd_active", 32'(rd_active), 32'd0);
    check("c_aw_hs", 32'(up_if.resp.aw_ready), 32'd1);
    tick();
    up_if.req.aw_valid = 1'b0;
    b_beat();
    tick();
    check("c_back_idle_wr_active", 32'(wr_active), 32'd0);

    // Two reads outstanding, AW arrives, drain, then AW plus 4 W beats.
    up_if.req.ar_valid = 1'b1;
    up_if.req.w_valid  = 1'b1;
    up_if.req.w.data   = 32'h5555_0000;
    settle();
    check("a_idle_w_stalled", 32'(up_if.resp.w_ready), 32'd0);
    tick();
    check("a_ar_hs1", 32'(up_if.resp.ar_ready), 32'd1);
    tick();
    check("a_ar_hs2", 32'(up_if.resp.ar_ready), 32'd1);
    tick();
    up_if.req.ar_valid = 1'b0;
    up_if.req.aw_valid = 1'b1;
    up_if.req.aw.addr  = 32'h0000_2000;
    settle();
    check("a_read_slv_aw_ready", 32'(up_if.resp.aw_ready), 32'd0);
    check("a_read_mst_aw_valid", 32'(dn_if.req.aw_valid), 32'd0);
    check("a_read_w_stalled", 32'(up_if.resp.w_ready), 32'd0);
    tick();
    check("a_drain_rd_active", 32'(rd_active), 32'd1);
    r_beat(32'hCAFE_0002);
    r_beat(32'hCAFE_0003);
    check("a_drain0_rd_active", 32'(rd_active), 32'd1);
    tick();
    check("a_write_wr_active", 32'(wr_active), 32'd1);
    check("a_aw_addr_pass", dn_if.req.aw.addr, 32'h0000_2000);
    check("a_aw_hs", 32'(up_if.resp.aw_ready), 32'd1);
    wbeats = 0;
    for (int i = 0; i < 4; i++) begin
      up_if.req.w.last = (i == 3);
      settle();
      if (up_if.req.w_valid && up_if.resp.w_ready && dn_if.req.w_valid) wbeats++;
      tick();
      if (i == 0) up_if.req.aw_valid = 1'b0;
    end
    up_if.req.w_valid = 1'b0;
    up_if.req.w.last  = 1'b0;
    check("a_w_beats", 32'(wbeats), 32'd4);
    b_beat();
    tick();
    check("a_back_idle_wr_active", 32'(wr_active), 32'd0);

    // Six back-to-back ARs with R held off: only 4 accepted until an R.last.
    up_if.req.ar_valid = 1'b1;
    settle();
    check("m_idle_ar_ready", 32'(up_if.resp.ar_ready), 32'd0);
    tick();
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      if (up_if.req.ar_valid && up_if.resp.ar_ready) hs++;
      tick();
    end
    check("m_ar_hs_count", 32'(hs), 32'd4);
    check("m_full_slv_ar_ready", 32'(up_if.resp.ar_ready), 32'd0);
    check("m_full_mst_ar_valid", 32'(dn_if.req.ar_valid), 32'd0);
    r_beat(32'hCAFE_0010);
    check("m_after_r_ar_ready", 32'(up_if.resp.ar_ready), 32'd1);
    tick();
    up_if.req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) r_beat(32'hCAFE_0020 + 32'(i));
    check("m_drained_rd_active", 32'(rd_active), 32'd1);
    tick();
    check("m_idle_rd_active", 32'(rd_active), 32'd0);

    // Contention after a read grant: write preferred; then switch back.
    up_if.req.ar_valid = 1'b1;
    up_if.req.aw_valid = 1'b1;
    tick();
    check("p_prio1_wr_active", 32'(wr_active), 32'd1);
    check("p_prio1_rd_active", 32'(rd_active), 32'd0);
    check("p_aw_hs", 32'(up_if.resp.aw_ready), 32'd1);
    check("p_write_ar_ready", 32'(up_if.resp.ar_ready), 32'd0);
    tick();
    up_if.req.aw_valid = 1'b0;
    tick();
    check("p_drainw_wr_active", 32'(wr_active), 32'd1);
    check("p_drainw_ar_ready", 32'(up_if.resp.ar_ready), 32'd0);
    b_beat();
    check("p_drainw0_wr_active", 32'(wr_active), 32'd1);
    tick();
    check("p_read_rd_active", 32'(rd_active), 32'd1);
    check("p_read_wr_active", 32'(wr_active), 32'd0);
    check("p_ar_hs", 32'(up_if.resp.ar_ready), 32'd1);
    tick();

    // rd_cnt=1: AR handshake and R.last in the same cycle keep it at 1.
    dn_if.resp.r_valid = 1'b1;
    dn_if.resp.r.last  = 1'b1;
    settle();
    check("s_ar_hs", 32'(up_if.resp.ar_ready), 32'd1);
    tick();
    up_if.req.ar_valid = 1'b0;
    dn_if.resp.r_valid = 1'b0;
    dn_if.resp.r.last  = 1'b0;
    settle();
    check("s_e1_rd_active", 32'(rd_active), 32'd1);
    tick();
    check("s_cnt_kept_rd_active", 32'(rd_active), 32'd1);
    r_beat(32'hCAFE_0030);
    check("s_last_rd_active", 32'(rd_active), 32'd1);
    tick();
    check("s_idle_rd_active", 32'(rd_active), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
